memory_stage: RTL and testbench

//  MEM stage of the 5-stage 16-bit pipeline: consumes EX/MEM register outputs, performs one load/store per instruction
//  on a variable-latency data memory via req/done handshake, stalls upstream while an access is outstanding, and

---
 rtl/memory_stage_pkg.sv | 16 +
 rtl/memory_stage_memwb_reg.sv | 81 ++++++++
 rtl/memory_stage.sv | 150 +++++++++++++++
 tb/tb_memory_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   mem_state_e  : FSM state encodings
//   DW_DEF       : default data/address width
//   TIMEOUT_DEF  : default maximum number of WAIT cycles before the stage errors out
package memory_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } mem_state_e;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 64;

endpackage

// File: rtl/memory_stage_memwb_reg.sv
// MEM/WB pipeline register bank (memwb_reg).
// When load_i=1 every field takes its next value. When load_i=0 a bubble is
// inserted instead: the control bits clear and the data fields hold.
// The asynchronous active-low rst clears every flop.
// Ports:
//   clk, rst                 clock, async active-low clear
//   load_i                   1 = load the instruction, 0 = insert a bubble
//   *_d_i                    next values for each MEM/WB field
//   *_o                      registered MEM/WB fields, createdump pulse
module memory_stage_memwb_reg #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] rdata_d_i,
    input  logic [DW-1:0] alu_d_i,
    input  logic [DW-1:0] pcs_d_i,
    input  logic [2:0]    wrr_d_i,
    input  logic          regwrite_d_i,
    input  logic          memtoreg_d_i,
    input  logic          halt_d_i,
    input  logic          jal_d_i,
    input  logic          dump_d_i,
    output logic [DW-1:0] rdata_o,
    output logic [DW-1:0] alu_o,
    output logic [DW-1:0] pcs_o,
    output logic [2:0]    wrr_o,
    output logic          regwrite_o,
    output logic          memtoreg_o,
    output logic          halt_o,
    output logic          jal_o,
    output logic          dump_o
);

    logic [DW-1:0] rdata_q, alu_q, pcs_q;
    logic [2:0]    wrr_q;
    logic          regwrite_q, memtoreg_q, halt_q, jal_q, dump_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q    <= '0;
            alu_q      <= '0;
            pcs_q      <= '0;
            wrr_q      <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
            jal_q      <= 1'b0;
            dump_q     <= 1'b0;
        end else if (load_i) begin
            rdata_q    <= rdata_d_i;
            alu_q      <= alu_d_i;
            pcs_q      <= pcs_d_i;
            wrr_q      <= wrr_d_i;
            regwrite_q <= regwrite_d_i;
            memtoreg_q <= memtoreg_d_i;
            halt_q     <= halt_d_i;
            jal_q      <= jal_d_i;
            dump_q     <= dump_d_i;
        end else begin
            // bubble: data fields hold, nothing downstream may act on them
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
            jal_q      <= 1'b0;
            dump_q     <= 1'b0;
        end
    end

    assign rdata_o    = rdata_q;
    assign alu_o      = alu_q;
    assign pcs_o      = pcs_q;
    assign wrr_o      = wrr_q;
    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign halt_o     = halt_q;
    assign jal_o      = jal_q;
    assign dump_o     = dump_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit 5-stage pipeline.
// Issues one load/store per instruction to a variable-latency data memory
// using a req/done handshake. Upstream stages are stalled while an access is
// outstanding, and the stage drives the MEM/WB register.
// It also flags misaligned accesses and memory timeouts on a sticky err.
//
//   state | meaning
//   IDLE  | no access outstanding; new instruction evaluated each cycle
//   WAIT  | request issued, waiting for mem_done; EX/MEM frozen
//   ERR   | memory timed out; permanent stall until reset
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   *_EXMEM                     EX/MEM pipeline register fields
//   mem_addr/wdata/req/wr       data memory request side
//   mem_rdata/done              data memory response side
//   stall_MEM                   freeze PC, IF/ID, ID/EX and EX/MEM
//   *_MEMWB, createdump         MEM/WB pipeline register fields
//   err                         sticky misalignment / timeout flag
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ALUO_EXMEM,
    input  logic [DW-1:0] Rd2_EXMEM,
    input  logic [DW-1:0] PCS_EXMEM,
    input  logic [2:0]    WrR_EXMEM,
    input  logic          RegWrite_EXMEM,
    input  logic          MemtoReg_EXMEM,
    input  logic          MemRead_EXMEM,
    input  logic          MemWrite_EXMEM,
    input  logic          Dump_EXMEM,
    input  logic          halt_EXMEM,
    input  logic          jumpAndLink_EXMEM,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          stall_MEM,
    output logic          createdump,
    output logic [DW-1:0] ReadData_MEMWB,
    output logic [DW-1:0] ALUO_MEMWB,
    output logic [DW-1:0] PCS_MEMWB,
    output logic [2:0]    WrR_MEMWB,
    output logic          RegWrite_MEMWB,
    output logic          MemtoReg_MEMWB,
    output logic          halt_MEMWB,
    output logic          jumpAndLink_MEMWB,
    output logic          err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    mem_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic          acc, misal, issue, in_idle, in_wait, in_err;
    logic          load_en, is_read;
    logic [DW-1:0] rdata_d;

    assign in_idle = rst & (state_q == ST_IDLE);
    assign in_wait = rst & (state_q == ST_WAIT);
    assign in_err  = rst & (state_q == ST_ERR);

    // A simultaneous read and write is illegal; handled like a misaligned access.
    assign acc     = MemRead_EXMEM | MemWrite_EXMEM;
    assign misal   = acc & (ALUO_EXMEM[0] | (MemRead_EXMEM & MemWrite_EXMEM));
    assign issue   = in_idle & acc & ~misal;
    assign is_read = MemRead_EXMEM & ~MemWrite_EXMEM & ~misal;

    // EX/MEM is frozen during WAIT, so passing these straight through keeps them stable.
    assign mem_addr  = ALUO_EXMEM;
    assign mem_wdata = Rd2_EXMEM;
    assign mem_wr    = MemWrite_EXMEM;
    assign mem_req   = issue;

    assign stall_MEM = (issue & ~mem_done) | (in_wait & ~mem_done) | in_err;
    assign load_en   = (in_idle & ~(issue & ~mem_done)) | (in_wait & mem_done);
    assign rdata_d   = is_read ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (misal) begin
                        err_q <= 1'b1;
                    end else if (issue && !mem_done) begin
                        cnt_q   <= CW'(1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign err = err_q;

    memory_stage_memwb_reg #(.DW(DW)) u_memwb (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_en),
        .rdata_d_i    (rdata_d),
        .alu_d_i      (ALUO_EXMEM),
        .pcs_d_i      (PCS_EXMEM),
        .wrr_d_i      (WrR_EXMEM),
        // a misaligned instruction must not write back and must stop the core
        .regwrite_d_i (RegWrite_EXMEM & ~misal),
        .memtoreg_d_i (MemtoReg_EXMEM),
        .halt_d_i     (halt_EXMEM | misal),
        .jal_d_i      (jumpAndLink_EXMEM),
        .dump_d_i     (Dump_EXMEM),
        .rdata_o      (ReadData_MEMWB),
        .alu_o        (ALUO_MEMWB),
        .pcs_o        (PCS_MEMWB),
        .wrr_o        (WrR_MEMWB),
        .regwrite_o   (RegWrite_MEMWB),
        .memtoreg_o   (MemtoReg_MEMWB),
        .halt_o       (halt_MEMWB),
        .jal_o        (jumpAndLink_MEMWB),
        .dump_o       (createdump)
    );

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int TMO = 64;

    logic        clk, rst;
    logic [15:0] ALUO_EXMEM, Rd2_EXMEM, PCS_EXMEM;
    logic [2:0]  WrR_EXMEM;
    logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
    logic        Dump_EXMEM, halt_EXMEM, jumpAndLink_EXMEM;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_wr, mem_done, stall_MEM, createdump, err;
    logic [15:0] ReadData_MEMWB, ALUO_MEMWB, PCS_MEMWB;
    logic [2:0]  WrR_MEMWB;
    logic        RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, jumpAndLink_MEMWB;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .PCS_EXMEM(PCS_EXMEM),
        .WrR_EXMEM(WrR_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .MemtoReg_EXMEM(MemtoReg_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .MemWrite_EXMEM(MemWrite_EXMEM), .Dump_EXMEM(Dump_EXMEM),
        .halt_EXMEM(halt_EXMEM), .jumpAndLink_EXMEM(jumpAndLink_EXMEM),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_MEM(stall_MEM),
        .createdump(createdump), .ReadData_MEMWB(ReadData_MEMWB),
        .ALUO_MEMWB(ALUO_MEMWB), .PCS_MEMWB(PCS_MEMWB), .WrR_MEMWB(WrR_MEMWB),
        .RegWrite_MEMWB(RegWrite_MEMWB), .MemtoReg_MEMWB(MemtoReg_MEMWB),
        .halt_MEMWB(halt_MEMWB), .jumpAndLink_MEMWB(jumpAndLink_MEMWB), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] aluo, rd2, pcs;
        logic [2:0]  wrr;
        logic        rw, m2r, mr, mw, dump, halt, jal;
    } ins_t;

    typedef struct {
        ins_t        in;
        logic        done;
        logic [15:0] rdata;
        logic        e_req, e_stall;
        logic [15:0] e_rd;
        logic        e_rw, e_halt, e_err, e_dump;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mki(input logic [15:0] aluo, input logic [15:0] rd2,
                                 input logic [2:0] wrr, input logic rw, input logic mr,
                                 input logic mw, input logic dump);
        ins_t r;
        r.aluo = aluo; r.rd2 = rd2; r.pcs = aluo ^ 16'h0F02; r.wrr = wrr;
        r.rw = rw; r.m2r = mr; r.mr = mr; r.mw = mw; r.dump = dump;
        r.halt = 1'b0; r.jal = 1'b0;
        return r;
    endfunction

    task automatic drive(input ins_t i);
        ALUO_EXMEM = i.aluo; Rd2_EXMEM = i.rd2; PCS_EXMEM = i.pcs; WrR_EXMEM = i.wrr;
        RegWrite_EXMEM = i.rw; MemtoReg_EXMEM = i.m2r; MemRead_EXMEM = i.mr;
        MemWrite_EXMEM = i.mw; Dump_EXMEM = i.dump; halt_EXMEM = i.halt;
        jumpAndLink_EXMEM = i.jal;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(mki(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        mem_done = 1'b0; mem_rdata = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs[7];

    // random-phase model state
    ins_t        cur;
    logic [15:0] rdat;
    logic        done_r, outst, dead, merr, prev_stall, accm, bad, e_req, e_stall, ld;
    int          wn, lat;
    logic [15:0] e_rd, e_alu, e_pcs;
    logic [2:0]  e_wrr;
    logic        e_rw, e_m2r, e_halt, e_jal, e_dump;

    initial begin
        rst = 1'b0;
        drive(mki(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        mem_done = 1'b0; mem_rdata = 16'h0;

        #2;
        chk("reset_stall", stall_MEM, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_err", err, 0);
        chk("reset_alu_memwb", ALUO_MEMWB, 0);
        chk("reset_dump", createdump, 0);

        // ---------------- table-driven single-cycle cases ----------------
        vecs[0] = '{mki(16'h1234, 16'h0000, 3'd1, 1, 0, 0, 1), 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1};
        vecs[1] = '{mki(16'h0010, 16'h0000, 3'd2, 1, 1, 0, 0), 1, 16'hBEEF, 1, 0, 16'hBEEF, 1, 0, 0, 0};
        vecs[2] = '{mki(16'h0020, 16'hAAAA, 3'd3, 0, 0, 1, 0), 1, 16'h5A5A, 1, 0, 16'h0000, 0, 0, 0, 0};
        vecs[3] = '{mki(16'h0033, 16'h0000, 3'd4, 1, 0, 0, 0), 1, 16'h5555, 0, 0, 16'h0000, 1, 0, 0, 0};
        vecs[4] = '{mki(16'h0021, 16'h0000, 3'd5, 1, 1, 0, 0), 1, 16'hCAFE, 0, 0, 16'h0000, 0, 1, 1, 0};
        vecs[5] = '{mki(16'h0040, 16'h0000, 3'd6, 1, 0, 0, 1), 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 1};
        vecs[6] = '{mki(16'h0044, 16'h0000, 3'd7, 1, 1, 1, 0), 1, 16'h1111, 0, 0, 16'h0000, 0, 1, 1, 0};

        do_reset();
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            drive(vecs[v].in);
            mem_done = vecs[v].done; mem_rdata = vecs[v].rdata;
            #1;
            chk($sformatf("vec%0d_req", v), mem_req, vecs[v].e_req);
            chk($sformatf("vec%0d_stall", v), stall_MEM, vecs[v].e_stall);
            if (vecs[v].e_req) begin
                chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].in.aluo);
                chk($sformatf("vec%0d_wr", v), mem_wr, vecs[v].in.mw);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rdata", v), ReadData_MEMWB, vecs[v].e_rd);
            chk($sformatf("vec%0d_alu", v), ALUO_MEMWB, vecs[v].in.aluo);
            chk($sformatf("vec%0d_wrr", v), WrR_MEMWB, vecs[v].in.wrr);
            chk($sformatf("vec%0d_regwrite", v), RegWrite_MEMWB, vecs[v].e_rw);
            chk($sformatf("vec%0d_halt", v), halt_MEMWB, vecs[v].e_halt);
            chk($sformatf("vec%0d_err", v), err, vecs[v].e_err);
            chk($sformatf("vec%0d_dump", v), createdump, vecs[v].e_dump);
        end

        // ---------------- 3-cycle store ----------------
        do_reset();
        begin
            int nreq, nstall;
            nreq = 0; nstall = 0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                drive(mki(16'h0020, 16'h1234, 3'd2, 0, 0, 1, 1));
                mem_done = (c == 3); mem_rdata = 16'hFFFF;
                #1;
                nreq += int'(mem_req);
                nstall += int'(stall_MEM);
                chk("st3_addr", mem_addr, 16'h0020);
                chk("st3_wdata", mem_wdata, 16'h1234);
                chk("st3_wr", mem_wr, 1);
                @(posedge clk); #1;
                chk($sformatf("st3_dump_c%0d", c), createdump, (c == 3));
            end
            chk("st3_req_cycles", nreq[15:0], 1);
            chk("st3_stall_cycles", nstall[15:0], 2);
            chk("st3_alu_memwb", ALUO_MEMWB, 16'h0020);
            @(negedge clk);
            drive(mki(16'h0002, 16'h0, 3'd1, 1, 0, 0, 0));
            mem_done = 1'b0;
            @(posedge clk); #1;
            chk("st3_dump_after", createdump, 0);
        end

        // ---------------- timeout ----------------
        do_reset();
        begin
            int err_edge, nreq, nlow;
            err_edge = -1; nreq = 0; nlow = 0;
            for (int k = 1; k <= 70; k++) begin
                @(negedge clk);
                drive(mki(16'h0040, 16'h0, 3'd3, 1, 1, 0, 0));
                mem_done = 1'b0;
                #1;
                nreq += int'(mem_req);
                if (!stall_MEM) nlow++;
                @(posedge clk); #1;
                if (err && err_edge < 0) err_edge = k;
            end
            chk("tmo_err_edge", err_edge[15:0], 16'(1 + TMO));
            chk("tmo_req_cycles", nreq[15:0], 1);
            chk("tmo_stall_low", nlow[15:0], 0);
            @(negedge clk);
            mem_done = 1'b1;
            #1;
            chk("tmo_stall_done", stall_MEM, 1);
            chk("tmo_req_done", mem_req, 0);
            @(posedge clk); #1;
            chk("tmo_err_sticky", err, 1);
            chk("tmo_bubble", RegWrite_MEMWB, 0);
        end

        // ---------------- reset mid-WAIT ----------------
        do_reset();
        @(negedge clk);
        drive(mki(16'h7777, 16'h0, 3'd5, 1, 0, 0, 0));
        mem_done = 1'b0;
        @(posedge clk); #1;
        chk("rmw_pre_alu", ALUO_MEMWB, 16'h7777);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            drive(mki(16'h0050, 16'h0, 3'd6, 1, 1, 0, 0));
            mem_done = 1'b0;
            if (c == 2) begin
                #1; rst = 1'b0; #1;
                chk("rmw_stall", stall_MEM, 0);
                chk("rmw_req", mem_req, 0);
                chk("rmw_alu", ALUO_MEMWB, 0);
                chk("rmw_wrr", WrR_MEMWB, 0);
                chk("rmw_err", err, 0);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst = 1'b1;
        drive(mki(16'h0066, 16'h0, 3'd4, 1, 0, 0, 0));
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        chk("rmw_late_stall", stall_MEM, 0);
        chk("rmw_late_req", mem_req, 0);
        @(posedge clk); #1;
        chk("rmw_late_rdata", ReadData_MEMWB, 0);
        chk("rmw_late_alu", ALUO_MEMWB, 16'h0066);
        chk("rmw_late_rw", RegWrite_MEMWB, 1);

        // ---------------- randomized run against reference model ----------------
        do_reset();
        outst = 0; dead = 0; merr = 0; prev_stall = 0; wn = 0; lat = 0;
        cur = mki(16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            int op;
            @(negedge clk);
            if (!prev_stall) begin
                op = int'($urandom_range(0, 15));
                cur = mki(16'($urandom) & 16'hFFFE, 16'($urandom), 3'($urandom),
                          1'($urandom), 1'b0, 1'b0, ($urandom_range(0, 5) == 0));
                cur.pcs = 16'($urandom);
                cur.halt = ($urandom_range(0, 15) == 0);
                cur.jal = ($urandom_range(0, 7) == 0);
                if (op >= 5 && op <= 9) begin cur.mr = 1; cur.m2r = 1; end
                if (op >= 10 && op <= 13) begin cur.mw = 1; cur.rw = 0; end
                if (op == 14) begin cur.mr = 1; cur.aluo[0] = 1'b1; end
                if (op == 15) cur.aluo[0] = 1'b1;
            end
            accm = cur.mr | cur.mw;
            bad  = accm & (cur.aluo[0] | (cur.mr & cur.mw));
            rdat = 16'($urandom);
            if (outst) done_r = (wn == lat);
            else if (accm && !bad && !dead) begin
                lat = int'($urandom_range(0, 4));
                done_r = (lat == 0);
            end else done_r = 1'($urandom);
            drive(cur);
            mem_done = done_r; mem_rdata = rdat;

            if (dead)            begin e_req = 0; e_stall = 1;       ld = 0;      end
            else if (outst)      begin e_req = 0; e_stall = !done_r; ld = done_r; end
            else if (bad)        begin e_req = 0; e_stall = 0;       ld = 1;      end
            else if (accm)       begin e_req = 1; e_stall = !done_r; ld = done_r; end
            else                 begin e_req = 0; e_stall = 0;       ld = 1;      end
            #1;
            chk("rnd_req", mem_req, e_req);
            chk("rnd_stall", stall_MEM, e_stall);
            if (e_req) begin
                chk("rnd_addr", mem_addr, cur.aluo);
                chk("rnd_wdata", mem_wdata, cur.rd2);
                chk("rnd_wr", mem_wr, cur.mw);
            end

            if (!dead) begin
                if (outst) begin
                    if (done_r) outst = 0;
                    else if (wn == TMO) begin dead = 1; merr = 1; end
                    else wn++;
                end else if (bad) merr = 1;
                else if (accm && !done_r) begin outst = 1; wn = 1; end
            end
            if (ld) begin
                e_rd = (cur.mr && !cur.mw && !bad) ? rdat : 16'h0;
                e_alu = cur.aluo; e_pcs = cur.pcs; e_wrr = cur.wrr;
                e_rw = cur.rw && !bad; e_m2r = cur.m2r; e_halt = cur.halt || bad;
                e_jal = cur.jal; e_dump = cur.dump;
            end else begin
                e_rw = 0; e_m2r = 0; e_halt = 0; e_jal = 0; e_dump = 0;
            end
            prev_stall = e_stall;

            @(posedge clk); #1;
            chk("rnd_regwrite", RegWrite_MEMWB, e_rw);
            chk("rnd_memtoreg", MemtoReg_MEMWB, e_m2r);
            chk("rnd_halt", halt_MEMWB, e_halt);
            chk("rnd_jal", jumpAndLink_MEMWB, e_jal);
            chk("rnd_dump", createdump, e_dump);
            chk("rnd_err", err, merr);
            if (ld) begin
                chk("rnd_rdata", ReadData_MEMWB, e_rd);
                chk("rnd_alu", ALUO_MEMWB, e_alu);
                chk("rnd_pcs", PCS_MEMWB, e_pcs);
                chk("rnd_wrr", WrR_MEMWB, e_wrr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
